// File: rtl/riscv_csr_file.sv
// rtl/riscv_csr_file.sv - machine-mode CSR file with trap/mret side effects and 64-bit counters
// csr_fun encoding: 2'b01 write, 2'b10 set, 2'b11 clear, 2'b00 read only.
module riscv_csr_file #(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] MTVEC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   csr_en,
  input  logic [11:0]            csr_addr,
  input  logic [1:0]             csr_fun,
  input  logic                   csr_no_wr,
  input  logic [WORD_LENGTH-1:0] reg_data,
  output logic [WORD_LENGTH-1:0] csr_rdata,
  output logic                   csr_illegal,
  input  logic                   instr_retire,
  input  logic                   trap_en,
  input  logic [WORD_LENGTH-1:0] trap_pc,
  input  logic [WORD_LENGTH-1:0] trap_cause,
  input  logic                   mret_en,
  output logic [WORD_LENGTH-1:0] mtvec_out,
  output logic [WORD_LENGTH-1:0] mepc_out,
  output logic                   mie_out
);
  localparam int XL = WORD_LENGTH;
  localparam logic [1:0] CSR_W = 2'b01;
  localparam logic [1:0] CSR_S = 2'b10;
  localparam logic [1:0] CSR_C = 2'b11;
  localparam logic [XL-1:0]   ALIGN_MASK = {{(XL-2){1'b1}}, 2'b00};
  localparam logic [2*XL-1:0] CNT_ONE    = {{(2*XL-1){1'b0}}, 1'b1};

  logic          mie_q, mie_d, mpie_q, mpie_d;
  logic [XL-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XL-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [2*XL-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [2*XL-1:0] cyc_inc, ins_inc;

  logic          mapped, wr_try, we;
  logic [XL-1:0] old_val, wdata, mstatus_rd;

  always_comb begin
    mstatus_rd    = '0;
    mstatus_rd[3] = mie_q;
    mstatus_rd[7] = mpie_q;
  end

  always_comb begin
    mapped  = 1'b1;
    old_val = '0;
    case (csr_addr)
      12'h300: old_val = mstatus_rd;
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'hB00, 12'hC00: old_val = mcycle_q[XL-1:0];
      12'hB02, 12'hC02: old_val = minstret_q[XL-1:0];
      12'hB80, 12'hC80: old_val = mcycle_q[2*XL-1:XL];
      12'hB82, 12'hC82: old_val = minstret_q[2*XL-1:XL];
      default: mapped = 1'b0;
    endcase
  end

  always_comb begin
    wdata = old_val;
    case (csr_fun)
      CSR_W:   wdata = reg_data;
      CSR_S:   wdata = old_val | reg_data;
      CSR_C:   wdata = old_val & ~reg_data;
      default: wdata = old_val;
    endcase
  end

  assign wr_try      = (csr_fun != 2'b00) && !csr_no_wr;
  assign csr_illegal = csr_en && (!mapped || ((csr_addr[11:8] == 4'hC) && wr_try));
  assign csr_rdata   = csr_illegal ? '0 : old_val;
  assign we          = csr_en && wr_try && !csr_illegal && !trap_en;

  assign cyc_inc = mcycle_q + CNT_ONE;
  assign ins_inc = minstret_q + {{(2*XL-1){1'b0}}, instr_retire};

  // A low-half write freezes the counter; a high-half write drops the low carry.
  always_comb begin
    mcycle_d   = cyc_inc;
    minstret_d = ins_inc;
    if (we && csr_addr == 12'hB00)      mcycle_d   = {mcycle_q[2*XL-1:XL], wdata};
    else if (we && csr_addr == 12'hB80) mcycle_d   = {wdata, cyc_inc[XL-1:0]};
    if (we && csr_addr == 12'hB02)      minstret_d = {minstret_q[2*XL-1:XL], wdata};
    else if (we && csr_addr == 12'hB82) minstret_d = {wdata, ins_inc[XL-1:0]};
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (we) begin
      case (csr_addr)
        12'h300: begin
          mie_d  = wdata[3];
          mpie_d = wdata[7];
        end
        12'h305: mtvec_d    = wdata & ALIGN_MASK;
        12'h340: mscratch_d = wdata;
        12'h341: mepc_d     = wdata & ALIGN_MASK;
        12'h342: mcause_d   = wdata;
        default: ;
      endcase
    end
    if (trap_en) begin
      mepc_d   = trap_pc & ALIGN_MASK;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_en) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mtvec_out = mtvec_q;
  assign mepc_out  = mepc_q;
  assign mie_out   = mie_q;
endmodule

// File: tb/tb_riscv_csr_file.sv
// tb/tb_riscv_csr_file.sv - directed and random checks of riscv_csr_file against a behavioural model
module tb_riscv_csr_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_en = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_fun = '0;
  logic        csr_no_wr = 1'b0;
  logic [31:0] reg_data = '0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instr_retire = 1'b0;
  logic        trap_en = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic        mret_en = 1'b0;
  logic [31:0] mtvec_out, mepc_out;
  logic        mie_out;

  int tests = 0;
  int fails = 0;

  // Behavioural model state: whole architectural registers.
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_mcycle, m_minstret;

  riscv_csr_file #(.WORD_LENGTH(32), .MTVEC_RESET(32'h103)) dut (
    .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .csr_addr(csr_addr), .csr_fun(csr_fun),
    .csr_no_wr(csr_no_wr), .reg_data(reg_data), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instr_retire(instr_retire), .trap_en(trap_en), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_en(mret_en), .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_out(mie_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mstatus = 0; m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_mcycle = 0; m_minstret = 0;
  endtask

  function automatic bit m_mapped(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02, 12'hB80,
                     12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82};
  endfunction

  function automatic logic [31:0] m_value(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00, 12'hC00: return m_mcycle[31:0];
      12'hB02, 12'hC02: return m_minstret[31:0];
      12'hB80, 12'hC80: return m_mcycle[63:32];
      12'hB82, 12'hC82: return m_minstret[63:32];
      default: return 0;
    endcase
  endfunction

  function automatic bit m_wants_write();
    return csr_fun != 0 && !csr_no_wr;
  endfunction

  function automatic bit m_illegal();
    return csr_en && (!m_mapped(csr_addr) || (csr_addr[11:8] == 4'hC && m_wants_write()));
  endfunction

  task automatic model_step();
    logic [31:0] old, nv;
    logic [63:0] ncyc, nins;
    bit wr, mie, mpie;
    old  = m_value(csr_addr);
    nv   = (csr_fun == 1) ? reg_data : (csr_fun == 2) ? (old | reg_data) : (old & ~reg_data);
    wr   = csr_en && m_wants_write() && !m_illegal() && !trap_en;
    ncyc = m_mcycle + 1;
    nins = m_minstret + (instr_retire ? 1 : 0);
    if (wr) begin
      case (csr_addr)
        12'h300: m_mstatus  = nv & 32'h88;
        12'h305: m_mtvec    = nv & ~32'h3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        12'hB00: ncyc = {m_mcycle[63:32], nv};
        12'hB80: ncyc = {nv, 32'(m_mcycle + 1)};
        12'hB02: nins = {m_minstret[63:32], nv};
        12'hB82: nins = {nv, 32'(m_minstret + (instr_retire ? 1 : 0))};
        default: ;
      endcase
    end
    mie  = m_mstatus[3];
    mpie = m_mstatus[7];
    if (trap_en) begin
      m_mepc    = trap_pc & ~32'h3;
      m_mcause  = trap_cause;
      m_mstatus = mie ? 32'h80 : 32'h0;
    end else if (mret_en) begin
      m_mstatus = 32'h80 | (mpie ? 32'h8 : 32'h0);
    end
    m_mcycle   = ncyc;
    m_minstret = nins;
  endtask

  task automatic set_in(input bit en, input logic [11:0] a, input logic [1:0] f, input bit nw,
                        input logic [31:0] d, input bit tr, input logic [31:0] pc,
                        input logic [31:0] ca, input bit mr, input bit ret);
    csr_en = en; csr_addr = a; csr_fun = f; csr_no_wr = nw; reg_data = d;
    trap_en = tr; trap_pc = pc; trap_cause = ca; mret_en = mr; instr_retire = ret;
  endtask

  task automatic rd(input logic [11:0] a);
    set_in(1, a, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_model(input string tag);
    #1;
    chk({tag, ".rdata"}, csr_rdata, m_illegal() ? 32'h0 : m_value(csr_addr));
    chk({tag, ".illegal"}, {31'b0, csr_illegal}, {31'b0, m_illegal()});
    chk({tag, ".mtvec"}, mtvec_out, m_mtvec);
    chk({tag, ".mepc"}, mepc_out, m_mepc);
    chk({tag, ".mie"}, {31'b0, mie_out}, {31'b0, m_mstatus[3]});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  logic [11:0] addr_tbl [13] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                                 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82};

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rd(12'h305); #1;
    chk("reset_mtvec_rd", csr_rdata, 32'h100);
    chk("reset_mtvec_out", mtvec_out, 32'h100);
    chk("reset_mie", {31'b0, mie_out}, 32'h0);
    chk("reset_mepc", mepc_out, 32'h0);
    rst_n = 1'b1;
    rd(12'hB00); check_model("cyc0"); chk("cyc0_const", csr_rdata, 32'h0); step();
    rd(12'hB00); check_model("cyc1"); chk("cyc1_const", csr_rdata, 32'h1); step();

    set_in(1, 12'h300, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1); check_model("mst_w"); step();
    rd(12'h300); check_model("mst_rd"); chk("mst_88", csr_rdata, 32'h88); step();
    set_in(1, 12'h300, 3, 0, 32'h8, 0, 0, 0, 0, 0); check_model("mst_c"); step();
    rd(12'h300); check_model("mst_rd2"); chk("mst_80", csr_rdata, 32'h80); step();
    set_in(1, 12'h300, 2, 1, 32'hFF, 0, 0, 0, 0, 0); check_model("mst_s_nowr");
    chk("nowr_legal", {31'b0, csr_illegal}, 32'h0); step();
    rd(12'h300); check_model("mst_rd3"); chk("mst_80b", csr_rdata, 32'h80); step();

    set_in(1, 12'hB80, 1, 0, 32'h0, 0, 0, 0, 0, 0); check_model("cych_w"); step();
    set_in(1, 12'hB00, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0); check_model("cycl_w"); step();
    rd(12'hB00); check_model("wrap_lo"); chk("wrap_lo_c", csr_rdata, 32'hFFFF_FFFF); step();
    rd(12'hB80); check_model("wrap_hi"); chk("wrap_hi_c", csr_rdata, 32'h1); step();

    set_in(1, 12'h340, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0); check_model("mscr_w"); step();
    set_in(1, 12'h300, 1, 0, 32'h8, 0, 0, 0, 0, 0); check_model("mie_set"); step();
    set_in(1, 12'h340, 1, 0, 32'hDEAD_BEEF, 1, 32'h203, 32'hB, 1, 1); check_model("trap"); step();
    rd(12'h300); check_model("post_trap");
    chk("trap_mepc", mepc_out, 32'h200);
    chk("trap_mie", {31'b0, mie_out}, 32'h0);
    chk("trap_mst", csr_rdata, 32'h80); step();
    rd(12'h342); check_model("trap_cause"); chk("trap_cause_c", csr_rdata, 32'hB); step();
    rd(12'h340); check_model("trap_mscr"); chk("trap_mscr_c", csr_rdata, 32'h1234_5678); step();
    set_in(0, 12'h0, 0, 0, 0, 0, 0, 0, 1, 0); step();
    rd(12'h300); check_model("mret"); chk("mret_mst", csr_rdata, 32'h88); step();

    set_in(1, 12'hC00, 1, 0, 32'h55, 0, 0, 0, 0, 0); check_model("ro_w");
    chk("ro_w_ill", {31'b0, csr_illegal}, 32'h1); step();
    rd(12'h7FF); check_model("unmapped");
    chk("unm_ill", {31'b0, csr_illegal}, 32'h1);
    chk("unm_rd", csr_rdata, 32'h0); step();

    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tbl[$urandom_range(0, 12)];
      set_in($urandom_range(0, 3) != 0, a, 2'($urandom), $urandom_range(0, 4) == 0, $urandom,
             $urandom_range(0, 7) == 0, $urandom, $urandom, $urandom_range(0, 7) == 0,
             1'($urandom));
      check_model("rand");
      step();
    end

    rd(12'hB00);
    #2 rst_n = 1'b0;
    model_reset();
    check_model("async_rst");
    chk("rst_mtvec", mtvec_out, 32'h100);
    chk("rst_cyc", csr_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(12'hB00); check_model("after_rst0"); step();
    rd(12'hB00); check_model("after_rst1"); chk("after_rst1_c", csr_rdata, 32'h1); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/riscv_csr_file.md
# riscv_csr_file

Machine-mode CSR register file for the core. It holds the M-mode trap CSRs and the 64-bit cycle and retired-instruction counters, and performs CSR read-modify-write operations (write, set, clear) in one cycle. It also applies the architectural side effects of trap entry and `mret`. It sits beside the execute stage: the decoder supplies the address, operation and write-suppress flag, and the trap controller consumes `mtvec_out`, `mepc_out` and `mie_out`.

## Interface
- WORD_LENGTH, 32, CSR and datapath word width; counters are 2*WORD_LENGTH wide.
- MTVEC_RESET, 0, reset value of mtvec; bits [1:0] are ignored.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- csr_en  in  1  a CSR instruction is executing this cycle.
- csr_addr  in  12  CSR address.
- csr_fun  in  CSR_FUN  CSR_W, CSR_S or CSR_C; any other value means read only, no write.
- csr_no_wr  in  1  write suppressed (S/C with rs1=x0 or zimm=0).
- reg_data  in  WORD_LENGTH  rs1 value or zero-extended zimm.
- csr_rdata  out  WORD_LENGTH  old CSR value, combinational.
- csr_illegal  out  1  illegal access, combinational.
- instr_retire  in  1  one instruction retires this cycle.
- trap_en  in  1  trap entry this cycle.
- trap_pc  in  WORD_LENGTH  PC of the trapping instruction.
- trap_cause  in  WORD_LENGTH  mcause value.
- mret_en  in  1  mret executes this cycle.
- mtvec_out, mepc_out  out  WORD_LENGTH  current register values.
- mie_out  out  1  mstatus.MIE.

## Operation
- Address map:
  - Read/write: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
  - Read-only shadows: cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82.
- New value computation:
  - CSR_W gives reg_data.
  - CSR_S gives old | reg_data.
  - CSR_C gives old & ~reg_data.
- A write occurs when all of the following hold: csr_en, csr_fun is W, S or C, csr_no_wr is 0, csr_illegal is 0, and trap_en is 0.
- csr_illegal is 1 when csr_en=1 and either:
  - the address is unmapped, or
  - a write is attempted to 0xCxx.
- On an illegal access, csr_rdata is 0 and no state changes.
- Field masks on write:
  - mstatus: only MIE (bit 3) and MPIE (bit 7) are stored; all other bits read 0.
  - mtvec and mepc: bits [1:0] are forced to 0.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instr_retire=1.
  - Both are 2*WORD_LENGTH bits and wrap from all-ones to 0.
- Counter write priority:
  - A write to the low half replaces the low half for that cycle (no increment). The high half is unchanged and receives no carry.
  - A write to the high half replaces the high half. The low half still increments, and its carry is discarded that cycle.
- Trap entry (trap_en=1): mepc ← trap_pc & ~3, mcause ← trap_cause, MPIE ← MIE, MIE ← 0.
- mret (mret_en=1): MIE ← MPIE, MPIE ← 1.
- Simultaneous events:
  - trap_en together with mret_en: trap wins.
  - trap_en together with a CSR write: the write is dropped.
  - Counters keep counting during a trap.
- Reset values:
  - mstatus 0, mtvec MTVEC_RESET & ~3, and all other registers 0.
  - Outputs: mie_out 0, mepc_out 0, mtvec_out MTVEC_RESET & ~3.

## Timing
- Read latency 0: csr_rdata reflects the pre-edge value in the same cycle.
- Writes, trap and mret effects are visible on all outputs the cycle after the edge.
- Counter reads return the value before this cycle's increment.
- rst_n low clears state immediately, independent of clk; the first increment occurs on the first edge after deassertion.

## Test plan
- Reset, then read 0x305 with MTVEC_RESET=0x103 → csr_rdata=0x100. Read 0xB00 on the first cycle after reset → 0, on the next cycle → 1.
- CSR_W 0x300 with 0xFFFFFFFF → read returns 0x88. Then CSR_C with 0x8 → 0x80. CSR_S with csr_no_wr=1 → no change, csr_illegal=0.
- Write 0xFFFFFFFF to 0xB00 and 0 to 0xB80 → the next two cycles read mcycle=0xFFFFFFFF then 0x00000000, with mcycleh=1.
- MIE=1, trap_en with trap_pc=0x203, cause=0xB, plus a concurrent CSR_W to 0x340 → mepc=0x200, mcause=0xB, MIE=0, MPIE=1, mscratch unchanged. Next mret → MIE=1, MPIE=1.
- CSR_W to 0xC00 → csr_illegal=1, no state change. Read 0x7FF → csr_illegal=1, csr_rdata=0.
- Assert rst_n=0 mid-count between clock edges → all registers 0 immediately; mtvec_out returns to its reset value.
